// File: rtl/data_sram_responder_pkg.sv
// Shared constants and types for the data-side SRAM-like responder.
// Holds the request size encodings, the response entry layout and the byte-lane merge.
package data_sram_responder_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] rdata;
    logic [CNT_W-1:0]  cnt;
  } resp_entry_t;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] merged;
    for (int b = 0; b < STRB_W; b++) begin
      merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_sram_responder_resp_queue.sv
// In-order response queue: each entry counts down from LATENCY-1 and the head
// is presented once its count reaches zero.
module data_sram_responder_resp_queue
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              push_wr,
  input  logic [DATA_W-1:0] push_rdata,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic              head_ready,
  output logic              head_wr,
  output logic [DATA_W-1:0] head_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  resp_entry_t      entry_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [PTR_W:0]   count_r;

  // Queue state: countdown on every live entry, push at tail, pop at head.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_r <= '0;
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_r[i] && (entry_r[i].cnt != '0)) begin
          entry_r[i].cnt <= entry_r[i].cnt - CNT_W'(1);
        end
      end
      if (pop) begin
        valid_r[rptr_r] <= 1'b0;
        rptr_r          <= rptr_r + PTR_W'(1);
      end
      if (push) begin
        entry_r[wptr_r] <= '{wr: push_wr, rdata: push_rdata, cnt: CNT_INIT};
        valid_r[wptr_r] <= 1'b1;
        wptr_r          <= wptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign full       = (count_r == (PTR_W+1)'(DEPTH));
  assign empty      = (count_r == '0);
  assign head_ready = valid_r[rptr_r] && (entry_r[rptr_r].cnt == '0);
  assign head_wr    = entry_r[rptr_r].wr;
  assign head_rdata = entry_r[rptr_r].rdata;

endmodule

// File: rtl/data_sram_responder.sv
// SRAM-like data-side slave: word memory with byte-lane stores and
// fixed-latency, strictly in-order responses through a bounded queue.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int IDX_W   = 12,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [STRB_W-1:0] data_sram_wstrb,
  input  logic [31:0]       data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  input  logic              stall,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [DATA_W-1:0] data_sram_rdata
);

  logic [DATA_W-1:0] mem_r [2**IDX_W];
  logic [IDX_W-1:0]  idx_s;
  logic              accept_s;
  logic              full_s;
  logic              empty_s;
  logic              head_ready_s;
  logic              head_wr_s;
  logic [DATA_W-1:0] head_rdata_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              unused_s;

  assign idx_s    = data_sram_addr[IDX_W+1:2];
  // Size and the out-of-range address bits never influence the access.
  assign unused_s = ^{data_sram_size, data_sram_addr[31:IDX_W+2], data_sram_addr[1:0]};

  assign data_sram_addr_ok = ~stall & ~full_s;
  assign accept_s          = data_sram_req & data_sram_addr_ok;
  assign rd_word_s         = mem_r[idx_s];

  // Store path: merge enabled byte lanes into the addressed word at the accept edge.
  always_ff @(posedge clk) begin
    if (accept_s && data_sram_wr) begin
      mem_r[idx_s] <= merge_bytes(mem_r[idx_s], data_sram_wdata, data_sram_wstrb);
    end
  end

  data_sram_responder_resp_queue #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_resp_queue (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept_s),
    .push_wr    (data_sram_wr),
    .push_rdata (rd_word_s),
    .pop        (head_ready_s),
    .full       (full_s),
    .empty      (empty_s),
    .head_ready (head_ready_s),
    .head_wr    (head_wr_s),
    .head_rdata (head_rdata_s)
  );

  assign data_sram_data_ok = head_ready_s & ~empty_s;
  assign data_sram_rdata   = (data_sram_data_ok && !head_wr_s) ? head_rdata_s : 32'd0;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized bench for data_sram_responder: two instances (LATENCY 1 / DEPTH 2 and
// LATENCY 6 / DEPTH 4) checked against an edge-indexed response model.
module tb_data_sram_responder;

  localparam int IW   = 4;
  localparam int NW   = 1 << IW;
  localparam int MAXC = 4096;
  localparam int D0   = 2;
  localparam int L0   = 1;
  localparam int D1   = 4;
  localparam int L1   = 6;

  logic        clk;
  logic        resetn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [1:0]  aok;
  logic [1:0]  dok;
  logic [1:0][31:0] rd;

  int checks;
  int failures;
  int cyc;

  bit        acc    [2][MAXC];
  bit        exp_ok [2][MAXC];
  bit [31:0] exp_rd [2][MAXC];
  bit [31:0] mem_m  [2][NW];

  data_sram_responder #(.IDX_W(IW), .DEPTH(D0), .LATENCY(L0)) dut0 (
    .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .stall(stall), .data_sram_addr_ok(aok[0]),
    .data_sram_data_ok(dok[0]), .data_sram_rdata(rd[0])
  );

  data_sram_responder #(.IDX_W(IW), .DEPTH(D1), .LATENCY(L1)) dut1 (
    .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .stall(stall), .data_sram_addr_ok(aok[1]),
    .data_sram_data_ok(dok[1]), .data_sram_rdata(rd[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat(input int k);
    return (k == 0) ? L0 : L1;
  endfunction

  function automatic int dep(input int k);
    return (k == 0) ? D0 : D1;
  endfunction

  // A request accepted at edge T is still queued after edge c while T > c - LATENCY.
  function automatic int outstanding(input int k);
    int n = 0;
    for (int c = cyc - lat(k) + 1; c <= cyc; c++) begin
      if (c >= 0 && acc[k][c]) n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, expv, cyc);
    end
  endtask

  // One clock: drive at the falling edge, check addr_ok, update model at the
  // rising edge, check data_ok/rdata at the next falling edge.
  task automatic step(input logic rq, input logic w, input logic [3:0] st,
                      input logic [31:0] a, input logic [31:0] wd, input logic stl);
    bit ea [2];
    int idx;
    req   = rq;
    wr    = w;
    wstrb = st;
    addr  = a;
    wdata = wd;
    stall = stl;
    size  = 2'($urandom_range(0, 2));
    idx   = int'(a[IW+1:2]);
    #1;
    for (int k = 0; k < 2; k++) begin
      ea[k] = !stl && (outstanding(k) < dep(k));
      chk($sformatf("addr_ok%0d", k), 32'(aok[k]), 32'(ea[k]));
    end
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rq && ea[k]) begin
        acc[k][cyc] = 1'b1;
        exp_ok[k][cyc + lat(k) - 1] = 1'b1;
        if (w) begin
          for (int b = 0; b < 4; b++) begin
            if (st[b]) mem_m[k][idx][8*b +: 8] = wd[8*b +: 8];
          end
          exp_rd[k][cyc + lat(k) - 1] = 32'd0;
        end else begin
          exp_rd[k][cyc + lat(k) - 1] = mem_m[k][idx];
        end
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("data_ok%0d", k), 32'(dok[k]), 32'(exp_ok[k][cyc]));
      chk($sformatf("rdata%0d", k), rd[k], exp_rd[k][cyc]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  // Asynchronous reset in the middle of the low clock phase; outstanding work is dropped.
  task automatic rst_mid();
    req   = 1'b0;
    stall = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_data_ok%0d", k), 32'(dok[k]), 32'd0);
      chk($sformatf("rst_rdata%0d", k), rd[k], 32'd0);
      for (int c = cyc - 20; c <= cyc + 20; c++) begin
        if (c >= 0) begin
          acc[k][c]    = 1'b0;
          exp_ok[k][c] = 1'b0;
          exp_rd[k][c] = 32'd0;
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    resetn   = 1'b0;
    req      = 1'b0;
    wr       = 1'b0;
    size     = 2'd0;
    wstrb    = 4'h0;
    addr     = 32'h0;
    wdata    = 32'h0;
    stall    = 1'b0;
    #3;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_data_ok%0d", k), 32'(dok[k]), 32'd0);
      chk($sformatf("reset_rdata%0d", k), rd[k], 32'd0);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Give every word a known value, spaced so the deeper instance never fills.
    for (int i = 0; i < NW; i++) begin
      step(1'b1, 1'b1, 4'hF, 32'(i) << 2, $urandom, 1'b0);
      step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    end
    idle(8);

    // Single store then load.
    step(1'b1, 1'b1, 4'hF, 32'h10, 32'h11223344, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    chk("single_load_l1", rd[0], 32'h11223344);
    idle(8);

    // Byte and half-word merge.
    step(1'b1, 1'b1, 4'hF, 32'h20, 32'h0, 1'b0);
    step(1'b1, 1'b1, 4'b0100, 32'h20, 32'hAAAAAAAA, 1'b0);
    step(1'b1, 1'b1, 4'b0011, 32'h20, 32'hBBBBBBBB, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0);
    chk("merge_l1", rd[0], 32'h00AABBBB);
    idle(8);

    // Back-to-back loads fill the deeper queue.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'h0, $urandom, 32'h0, 1'b0);
    idle(10);

    // Read-after-write while the store response is still pending.
    step(1'b1, 1'b1, 4'hF, 32'h30, 32'hDEADBEEF, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 1'b0);
    chk("raw_l1", rd[0], 32'hDEADBEEF);
    idle(8);

    // Stall with two requests outstanding; responses must still drain.
    step(1'b1, 1'b1, 4'hF, 32'h34, 32'hCAFEF00D, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b1);

    // Reset with the deeper queue holding work; stores survive.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, 32'h34, 32'h0, 1'b0);
    rst_mid();
    idle(8);
    step(1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h34, 32'h0, 1'b0);
    chk("after_reset_l1", rd[0], 32'hCAFEF00D);
    step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    idle(8);

    // Randomized traffic with alternating bursty and sparse phases.
    for (int i = 0; i < 700; i++) begin
      bit burst;
      bit rq;
      bit stl;
      burst = ((i / 50) % 2) == 1;
      rq    = burst ? 1'b1 : ($urandom_range(0, 2) != 0);
      stl   = burst ? 1'b0 : ($urandom_range(0, 7) == 0);
      step(rq, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom, stl);
      if (i == 400) rst_mid();
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
